issue_retirer: RTL

Retires convolution results from the allocator array in issue order and streams them to the output image buffer. It sits on the return path of the issue positioner: the positioner hands window `k` to allocator `k mod num_allocators`, and this block collects allocator results in that same round-robin order. For each result it computes the raster output pixel address, writes the result through a valid/ready port, and releases the allocator with an acknowledge pulse.

---
 rtl/issue_retirer_if.sv | 25 ++
 rtl/issue_retirer.sv | 106 ++++++++++
 2 files changed

// File: rtl/issue_retirer_if.sv
// Allocator return bus and output-buffer write port of the issue retirer.
interface issue_retirer_if #(
  parameter int num_allocators = 220,
  parameter int data_width     = 16
);
  logic [num_allocators-1:0]            alloc_valid;
  logic [num_allocators*data_width-1:0] alloc_data;
  logic [num_allocators-1:0]            alloc_ack;
  logic                                 wr_valid;
  logic                                 wr_ready;
  logic [15:0]                          wr_addr;
  logic [data_width-1:0]                wr_data;

  // master: the retirer itself
  modport master (
    input  alloc_valid, alloc_data, wr_ready,
    output alloc_ack, wr_valid, wr_addr, wr_data
  );

  // slave: allocator array plus output buffer
  modport slave (
    output alloc_valid, alloc_data, wr_ready,
    input  alloc_ack, wr_valid, wr_addr, wr_data
  );
endinterface

// File: rtl/issue_retirer.sv
// Retires allocator results in round-robin issue order and writes them to
// the output image buffer at raster address out_y*out_dim + out_x.
module issue_retirer #(
  parameter int num_allocators = 220,
  parameter int data_width     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            out_dim,
  input  logic                  start,
  issue_retirer_if.master       bus,
  output logic [7:0]            out_x,
  output logic [7:0]            out_y,
  output logic                  busy,
  output logic                  done
);
  localparam int PW = (num_allocators > 1) ? $clog2(num_allocators) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, WRITE, DONE} state_t;

  state_t                    state, state_nxt;
  logic [PW-1:0]             ptr;
  logic [7:0]                dim;
  logic [15:0]               wr_addr_q;
  logic [data_width-1:0]     wr_data_q;
  logic [num_allocators-1:0] ack_q;
  logic                      take, hs, last;
  logic [15:0]               addr_calc;

  assign addr_calc = 16'(out_y) * 16'(dim) + 16'(out_x);
  assign last      = (out_x == 8'(dim - 8'd1)) && (out_y == 8'(dim - 8'd1));

  assign bus.alloc_ack = ack_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state and status outputs; only the current pointer's valid matters.
  always_comb begin
    state_nxt    = state;
    take         = 1'b0;
    hs           = 1'b0;
    bus.wr_valid = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = (out_dim == 8'd0) ? DONE : WAIT;
      WAIT: begin
        busy = 1'b1;
        take = bus.alloc_valid[ptr];
        if (take) state_nxt = WRITE;
      end
      WRITE: begin
        busy         = 1'b1;
        bus.wr_valid = 1'b1;
        hs           = bus.wr_ready;
        if (hs) state_nxt = last ? DONE : WAIT;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: pass setup, result capture with ack pulse, pointer/coordinate advance.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr       <= '0;
      dim       <= '0;
      out_x     <= '0;
      out_y     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ack_q     <= '0;
    end else begin
      ack_q <= '0;
      if (state == IDLE && start) begin
        ptr   <= '0;
        out_x <= '0;
        out_y <= '0;
        dim   <= out_dim;
      end
      if (take) begin
        wr_data_q <= bus.alloc_data[ptr*data_width +: data_width];
        wr_addr_q <= addr_calc;
        ack_q     <= num_allocators'(1) << ptr;
      end
      if (hs) begin
        ptr <= (ptr == PW'(num_allocators - 1)) ? '0 : ptr + 1'b1;
        if (out_x == 8'(dim - 8'd1)) begin
          out_x <= '0;
          out_y <= out_y + 8'd1;
        end else begin
          out_x <= out_x + 8'd1;
        end
      end
    end
  end
endmodule
